ma_channel_scheduler: RTL

- Time-multiplexes one serial 3-tap moving-average datapath across NCH input channels.
- Each channel keeps its own 3-sample delay line inside this block. A round-robin arbiter picks one pending channel, accepts its sample, and accumulates the tap-enabled delayed samples over 3 cycles.
- The block presents the result with the channel tag on a valid/ready output port.
- It sits between the multi-channel sample sources and the downstream result consumer, replacing one filter instance per channel.

---
 rtl/ma_channel_scheduler_if.sv | 29 ++
 rtl/ma_channel_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ma_channel_scheduler_if.sv
// Handshake bundle for the multi-channel moving-average scheduler:
// per-channel sample inputs with one-hot accept, tap mask, and tagged result output.
interface ma_channel_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2
);
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic [2:0]           b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_ch;
  logic                 busy;

  // Sample sources and result consumer side.
  modport master (
    output in_valid, in_data, b, out_ready,
    input  in_ready, out_valid, out_data, out_ch, busy
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, b, out_ready,
    output in_ready, out_valid, out_data, out_ch, busy
  );
endinterface

// File: rtl/ma_channel_scheduler.sv
// Shares one serial 3-tap moving-average datapath across NCH channels, each with
// its own delay line, using a round-robin arbiter and a tagged valid/ready result.
module ma_channel_scheduler #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ma_channel_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TAP0, TAP1, TAP2, OUT} state_t;
  typedef logic signed [WIDTH+1:0] acc_t;

  localparam int SAT_HI = 2**(WIDTH-1) - 1;
  localparam int SAT_LO = -(2**(WIDTH-1));

  state_t                   state;
  logic [CHW-1:0]           rr_ptr;
  logic [CHW-1:0]           cur_ch;
  logic [2:0]               b_lat;
  acc_t                     acc;
  logic signed [WIDTH-1:0]  hist [NCH][3];
  logic                     out_valid_q;
  logic [WIDTH-1:0]         out_data_q;
  logic [CHW-1:0]           out_ch_q;

  logic [CHW-1:0]           grant_ch;
  logic [CHW-1:0]           idx;
  logic                     grant_found;
  logic [NCH-1:0]           one_hot;
  logic                     xfer;
  logic signed [WIDTH-1:0]  sample;
  acc_t                     acc_sum;

  function automatic acc_t tap_term(input logic en, input logic signed [WIDTH-1:0] s);
    return en ? acc_t'({{2{s[WIDTH-1]}}, s}) : '0;
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input acc_t a);
    if (a > acc_t'(SAT_HI)) return {1'b0, {(WIDTH-1){1'b1}}};
    if (a < acc_t'(SAT_LO)) return {1'b1, {(WIDTH-1){1'b0}}};
    return a[WIDTH-1:0];
  endfunction

  // Round-robin search starts just past the last granted channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    grant_ch    = '0;
    grant_found = 1'b0;
    idx         = '0;
    one_hot     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CHW'((int'(rr_ptr) + k) % NCH);
      if (!grant_found && bus.in_valid[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
    one_hot[grant_ch] = grant_found;
  end

  assign bus.in_ready = (state == IDLE && !rst) ? one_hot : '0;
  assign xfer         = |(bus.in_valid & bus.in_ready);
  assign sample       = bus.in_data[int'(grant_ch)*WIDTH +: WIDTH];
  assign acc_sum      = acc + tap_term(b_lat[2], hist[cur_ch][2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= CHW'(NCH-1);
      cur_ch      <= '0;
      b_lat       <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      // NOTE: the delay lines are reset because a stale history would leak into the first results after reset.
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < 3; t++)
          hist[c][t] <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignment so each register sees pre-edge values of the others.
      case (state)
        IDLE: if (xfer) begin
          cur_ch            <= grant_ch;
          rr_ptr            <= grant_ch;
          b_lat             <= bus.b;
          hist[grant_ch][2] <= hist[grant_ch][1];
          hist[grant_ch][1] <= hist[grant_ch][0];
          hist[grant_ch][0] <= sample;
          state             <= TAP0;
        end
        TAP0: begin
          acc   <= tap_term(b_lat[0], hist[cur_ch][0]);
          state <= TAP1;
        end
        TAP1: begin
          acc   <= acc + tap_term(b_lat[1], hist[cur_ch][1]);
          state <= TAP2;
        end
        TAP2: begin
          acc         <= acc_sum;
          out_valid_q <= 1'b1;
          out_data_q  <= saturate(acc_sum);
          out_ch_q    <= cur_ch;
          state       <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state != IDLE);

endmodule
